// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: turns 32-bit fetched words into a stream of 16/32-bit
// instructions with their PCs, handling instructions that straddle word boundaries.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_inst_pc,
  output logic        out_inst_compressed,
  input  logic        out_ready
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:1], 1'b0};

  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_word_reg, buf_word_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [15:0] span_half_reg, span_half_next;
  logic        span_valid_reg, span_valid_next;
  logic        fetch_busy_reg, fetch_busy_next;
  logic        drop_next_reg, drop_next_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_inst_reg, out_inst_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic        out_comp_reg, out_comp_next;

  logic        can_load;
  logic        emit;
  logic [31:0] emit_inst;
  logic        lo_full;
  logic        hi_full;
  logic        rollback_pc_unused;

  assign rollback_pc_unused = rollback_pc[0];

  assign can_load = !out_valid_reg || out_ready;
  assign lo_full  = (buf_word_reg[1:0] == 2'b11);
  assign hi_full  = (buf_word_reg[17:16] == 2'b11);

  always_comb begin
    pc_next         = pc_reg;
    buf_word_next   = buf_word_reg;
    buf_valid_next  = buf_valid_reg;
    span_half_next  = span_half_reg;
    span_valid_next = span_valid_reg;
    fetch_busy_next = fetch_busy_reg;
    drop_next_next  = drop_next_reg;
    fetch_addr_next = fetch_addr_reg;
    out_valid_next  = out_valid_reg;
    out_inst_next   = out_inst_reg;
    out_pc_next     = out_pc_reg;
    out_comp_next   = out_comp_reg;
    emit            = 1'b0;
    emit_inst       = 32'h0;

    if (rollback) begin
      // The outstanding request cannot be cancelled, so its response is marked for discard.
      pc_next         = {rollback_pc[31:1], 1'b0};
      buf_valid_next  = 1'b0;
      span_valid_next = 1'b0;
      out_valid_next  = 1'b0;
      if (fetch_busy_reg) begin
        if (fetch_valid) begin
          fetch_busy_next = 1'b0;
          drop_next_next  = 1'b0;
        end else begin
          drop_next_next  = 1'b1;
        end
      end
    end else begin
      if (fetch_busy_reg && fetch_valid) begin
        fetch_busy_next = 1'b0;
        if (drop_next_reg) begin
          drop_next_next = 1'b0;
        end else begin
          buf_word_next  = fetch_data;
          buf_valid_next = 1'b1;
          if (span_valid_reg && can_load) begin
            emit            = 1'b1;
            emit_inst       = {fetch_data[15:0], span_half_reg};
            pc_next         = pc_reg + 32'd4;
            span_valid_next = 1'b0;
          end
        end
      end else if (buf_valid_reg && can_load) begin
        // A pending span whose second half arrived during an output stall completes here.
        if (span_valid_reg) begin
          emit            = 1'b1;
          emit_inst       = {buf_word_reg[15:0], span_half_reg};
          pc_next         = pc_reg + 32'd4;
          span_valid_next = 1'b0;
        end else if (!pc_reg[1]) begin
          emit = 1'b1;
          if (lo_full) begin
            emit_inst      = buf_word_reg;
            pc_next        = pc_reg + 32'd4;
            buf_valid_next = 1'b0;
          end else begin
            emit_inst = {16'h0, buf_word_reg[15:0]};
            pc_next   = pc_reg + 32'd2;
          end
        end else if (hi_full) begin
          span_half_next  = buf_word_reg[31:16];
          span_valid_next = 1'b1;
          buf_valid_next  = 1'b0;
        end else begin
          emit           = 1'b1;
          emit_inst      = {16'h0, buf_word_reg[31:16]};
          pc_next        = pc_reg + 32'd2;
          buf_valid_next = 1'b0;
        end
      end

      if (!buf_valid_reg && !fetch_busy_reg) begin
        fetch_busy_next = 1'b1;
        fetch_addr_next = span_valid_reg ? {pc_reg[31:2] + 30'd1, 2'b00}
                                         : {pc_reg[31:2], 2'b00};
      end

      if (can_load) begin
        out_valid_next = emit;
        if (emit) begin
          out_inst_next = emit_inst;
          out_pc_next   = pc_reg;
          out_comp_next = (emit_inst[1:0] != 2'b11);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg         <= RESET_PC_ALIGNED;
      buf_word_reg   <= 32'h0;
      buf_valid_reg  <= 1'b0;
      span_half_reg  <= 16'h0;
      span_valid_reg <= 1'b0;
      fetch_busy_reg <= 1'b0;
      drop_next_reg  <= 1'b0;
      fetch_addr_reg <= 32'h0;
      out_valid_reg  <= 1'b0;
      out_inst_reg   <= 32'h0;
      out_pc_reg     <= 32'h0;
      out_comp_reg   <= 1'b0;
    end else if (rdy) begin
      pc_reg         <= pc_next;
      buf_word_reg   <= buf_word_next;
      buf_valid_reg  <= buf_valid_next;
      span_half_reg  <= span_half_next;
      span_valid_reg <= span_valid_next;
      fetch_busy_reg <= fetch_busy_next;
      drop_next_reg  <= drop_next_next;
      fetch_addr_reg <= fetch_addr_next;
      out_valid_reg  <= out_valid_next;
      out_inst_reg   <= out_inst_next;
      out_pc_reg     <= out_pc_next;
      out_comp_reg   <= out_comp_next;
    end
  end

  assign fetch_req           = fetch_busy_reg;
  assign fetch_addr          = fetch_addr_reg;
  assign out_inst_valid      = out_valid_reg;
  assign out_inst            = out_inst_reg;
  assign out_inst_pc         = out_pc_reg;
  assign out_inst_compressed = out_comp_reg;

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: a memory responder serves fetches, monitors
// compare fetch addresses and emitted instructions against hand-computed queues.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [31:0] rollback_pc = 32'h0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_data = 32'h0;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        out_inst_compressed;
  logic        out_ready = 1'b1;

  fetch_aligner #(.RESET_PC(32'h0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .rollback            (rollback),
    .rollback_pc         (rollback_pc),
    .fetch_req           (fetch_req),
    .fetch_addr          (fetch_addr),
    .fetch_valid         (fetch_valid),
    .fetch_data          (fetch_data),
    .out_inst_valid      (out_inst_valid),
    .out_inst            (out_inst),
    .out_inst_pc         (out_inst_pc),
    .out_inst_compressed (out_inst_compressed),
    .out_ready           (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          acc_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        resp_hold = 1'b0;
  logic        req_prev = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %h, required nothing", name, act);
  endtask

  task automatic exp_out(input logic [31:0] inst, input logic [31:0] pc, input logic comp);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.comp = comp;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers a held request from the table, one cycle after seeing it.
  always begin
    @(posedge clk);
    #2;
    fetch_valid = 1'b0;
    if (rst && rdy && fetch_req && !resp_hold && mem.exists(fetch_addr)) begin
      fetch_valid = 1'b1;
      fetch_data  = mem[fetch_addr];
    end
  end

  // Monitor: checks every new fetch request and every presented instruction.
  always @(negedge clk) begin
    if (!rst) begin
      req_prev = 1'b0;
    end else begin
      if (fetch_req && !req_prev) begin
        if (addr_q.size() == 0) fail_now("unexpected_fetch", fetch_addr);
        else chk("fetch_addr", fetch_addr, addr_q.pop_front());
      end
      req_prev = fetch_req;
      if (out_inst_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out", out_inst);
        end else begin
          chk("out_inst", out_inst, exp_q[0].inst);
          chk("out_inst_pc", out_inst_pc, exp_q[0].pc);
          chk("out_inst_compressed", {31'h0, out_inst_compressed}, {31'h0, exp_q[0].comp});
          if (out_ready && rdy) begin
            void'(exp_q.pop_front());
            acc_q.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, out_inst_valid}, 32'h0);
    chk("rst_fetch_req", {31'h0, fetch_req}, 32'h0);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_inst_pc, 32'h0);
    chk("rst_out_comp", {31'h0, out_inst_compressed}, 32'h0);
    exp_q.delete();
    addr_q.delete();
    acc_q.delete();
    mem.delete();
    rdy = 1'b1;
    rollback = 1'b0;
    out_ready = 1'b1;
    resp_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) fail_now({name, "_timeout"}, exp_q.size() + addr_q.size());
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string name, input int which);
    int n;
    n = 0;
    while (n < 100 && !((which == 0 && fetch_req) || (which == 1 && out_inst_valid) ||
                        (which == 2 && acc_q.size() != 0))) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now({name, "_wait_timeout"}, which);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    // Single 32-bit instruction.
    do_reset();
    mem[32'h0] = 32'h00000013;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    exp_out(32'h00000013, 32'h0, 1'b0);
    wait_done("single_full");

    // Two compressed instructions in one word, back to back.
    do_reset();
    mem[32'h0] = 32'h45054501;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    exp_out(32'h00004501, 32'h0, 1'b1);
    exp_out(32'h00004505, 32'h2, 1'b1);
    wait_done("two_compressed");
    if (acc_q.size() >= 2) chk("consecutive_gap", acc_q[1] - acc_q[0], 32'd1);
    else fail_now("consecutive_missing", acc_q.size());

    // 32-bit instruction spanning a word boundary.
    do_reset();
    mem[32'h0] = 32'h00134501;
    mem[32'h4] = 32'h45050000;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    exp_out(32'h00004501, 32'h0, 1'b1);
    exp_out(32'h00000013, 32'h2, 1'b0);
    exp_out(32'h00004505, 32'h6, 1'b1);
    wait_done("spanning");

    // Downstream stall for 3 cycles: held output, accepted once.
    do_reset();
    out_ready = 1'b0;
    mem[32'h0] = 32'h45054501;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    exp_out(32'h00004501, 32'h0, 1'b1);
    exp_out(32'h00004505, 32'h2, 1'b1);
    wait_sig("stall", 1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("stall");

    // Rollback with a fetch outstanding; the stale response must be dropped.
    do_reset();
    resp_hold = 1'b1;
    mem[32'h0]   = 32'h00010001;
    mem[32'h100] = 32'h45050001;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    exp_out(32'h00004505, 32'h102, 1'b1);
    wait_sig("rollback", 0);
    @(posedge clk);
    #1;
    rollback = 1'b1;
    rollback_pc = 32'h103;
    @(posedge clk);
    #1;
    rollback = 1'b0;
    @(negedge clk);
    chk("rollback_out_valid", {31'h0, out_inst_valid}, 32'h0);
    @(posedge clk);
    #1;
    resp_hold = 1'b0;
    wait_done("rollback");

    // Enable dropped for 4 cycles in the middle of a stream.
    do_reset();
    mem[32'h0] = 32'h45054501;
    mem[32'h4] = 32'h00134501;
    mem[32'h8] = 32'h45050000;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    addr_q.push_back(32'hC);
    exp_out(32'h00004501, 32'h0, 1'b1);
    exp_out(32'h00004505, 32'h2, 1'b1);
    exp_out(32'h00004501, 32'h4, 1'b1);
    exp_out(32'h00000013, 32'h6, 1'b0);
    exp_out(32'h00004505, 32'hA, 1'b1);
    wait_sig("freeze", 2);
    rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_done("freeze");

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
